alu_rs: RTL

Reservation station for the integer ALU. It holds up to `RS_SIZE` dispatched instructions, waits for their source operands by snooping the two result broadcast buses (ALU and load unit), and issues one ready instruction per cycle on registered outputs to the ALU. It sits between the dispatcher and the ALU. The ALU's combinational result and tag feed back into this block as one of the broadcast buses.

---
 rtl/alu_rs.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_rs.sv
// Integer ALU reservation station: snoops ALU/load broadcasts, issues one ready entry per cycle.
// Optional ALU_RS_AGE_ORDER_EN selects oldest-ready issue instead of lowest-index-ready.
module alu_rs #(
  parameter int unsigned RS_SIZE = 8,
  parameter int unsigned OP_W    = 6,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned XLEN    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [OP_W-1:0]          in_op,
  input  logic [TAG_W-1:0]         in_rob_tag,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_imm,
  input  logic [TAG_W-1:0]         in_qj,
  input  logic [TAG_W-1:0]         in_qk,
  input  logic [XLEN-1:0]          in_vj,
  input  logic [XLEN-1:0]          in_vk,
  input  logic [TAG_W-1:0]         alu_cdb_tag,
  input  logic [XLEN-1:0]          alu_cdb_val,
  input  logic [TAG_W-1:0]         ls_cdb_tag,
  input  logic [XLEN-1:0]          ls_cdb_val,
  output logic                     full,
  output logic [$clog2(RS_SIZE):0] occupancy,
  output logic [OP_W-1:0]          out_op,
  output logic [TAG_W-1:0]         out_rob_tag,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_a,
  output logic [XLEN-1:0]          out_b,
  output logic [XLEN-1:0]          out_imm
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [RS_SIZE-1:0] r_busy;
  logic [OP_W-1:0]    r_op  [RS_SIZE];
  logic [TAG_W-1:0]   r_tag [RS_SIZE];
  logic [XLEN-1:0]    r_pc  [RS_SIZE];
  logic [XLEN-1:0]    r_imm [RS_SIZE];
  logic [XLEN-1:0]    r_vj  [RS_SIZE];
  logic [XLEN-1:0]    r_vk  [RS_SIZE];
  logic [TAG_W-1:0]   r_qj  [RS_SIZE];
  logic [TAG_W-1:0]   r_qk  [RS_SIZE];

  logic               r_full;
  logic [CNT_W-1:0]   r_occ;
  logic [OP_W-1:0]    r_out_op;
  logic [TAG_W-1:0]   r_out_tag;
  logic [XLEN-1:0]    r_out_pc;
  logic [XLEN-1:0]    r_out_a;
  logic [XLEN-1:0]    r_out_b;
  logic [XLEN-1:0]    r_out_imm;

  logic [RS_SIZE-1:0] w_ready;
  logic [RS_SIZE-1:0] w_busy_d;
  logic [CNT_W-1:0]   w_occ_d;
  logic               w_alloc;
  logic               w_free_found;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_iss_found;
  logic [IDX_W-1:0]   w_iss_idx;
  logic [TAG_W-1:0]   w_in_qj;
  logic [TAG_W-1:0]   w_in_qk;
  logic [XLEN-1:0]    w_in_vj;
  logic [XLEN-1:0]    w_in_vk;

  // Operands broadcast in the dispatch cycle are captured at allocation; ALU bus wins ties.
  always_comb begin
    w_in_qj = in_qj;
    w_in_vj = in_vj;
    w_in_qk = in_qk;
    w_in_vk = in_vk;
    if (in_qj != '0 && in_qj == alu_cdb_tag) begin
      w_in_qj = '0;
      w_in_vj = alu_cdb_val;
    end else if (in_qj != '0 && in_qj == ls_cdb_tag) begin
      w_in_qj = '0;
      w_in_vj = ls_cdb_val;
    end
    if (in_qk != '0 && in_qk == alu_cdb_tag) begin
      w_in_qk = '0;
      w_in_vk = alu_cdb_val;
    end else if (in_qk != '0 && in_qk == ls_cdb_tag) begin
      w_in_qk = '0;
      w_in_vk = ls_cdb_val;
    end
  end

  always_comb begin
    w_ready      = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
      w_ready[i] = r_busy[i] && (r_qj[i] == '0) && (r_qk[i] == '0);
      if (!r_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

`ifdef ALU_RS_AGE_ORDER_EN
  logic [CNT_W-1:0] r_seq [RS_SIZE];
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_rel;
  logic [CNT_W-1:0] w_best;

  // Live entries span at most RS_SIZE allocations, so (seq - cnt) orders them by age.
  always_comb begin
    w_iss_found = 1'b0;
    w_iss_idx   = '0;
    w_best      = '1;
    w_rel       = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      w_rel = r_seq[i] - r_cnt;
      if (w_ready[i] && (!w_iss_found || w_rel < w_best)) begin
        w_iss_found = 1'b1;
        w_iss_idx   = IDX_W'(i);
        w_best      = w_rel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      for (int i = 0; i < int'(RS_SIZE); i++) r_seq[i] <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_alloc) begin
      r_seq[w_free_idx] <= r_cnt;
      r_cnt             <= r_cnt + CNT_W'(1);
    end
  end
`else
  always_comb begin
    w_iss_found = 1'b0;
    w_iss_idx   = '0;
    for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_iss_found = 1'b1;
        w_iss_idx   = IDX_W'(i);
      end
    end
  end
`endif

  assign w_alloc = in_valid && !r_full && w_free_found && !flush;

  always_comb begin
    w_busy_d = r_busy;
    if (flush) begin
      w_busy_d = '0;
    end else begin
      if (w_iss_found) w_busy_d[w_iss_idx] = 1'b0;
      if (w_alloc)     w_busy_d[w_free_idx] = 1'b1;
    end
    w_occ_d = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) w_occ_d = w_occ_d + CNT_W'(w_busy_d[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_full <= 1'b0;
      r_occ  <= '0;
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        r_op[i]  <= '0;
        r_tag[i] <= '0;
        r_pc[i]  <= '0;
        r_imm[i] <= '0;
        r_vj[i]  <= '0;
        r_vk[i]  <= '0;
        r_qj[i]  <= '0;
        r_qk[i]  <= '0;
      end
    end else begin
      r_busy <= w_busy_d;
      r_occ  <= w_occ_d;
      r_full <= (w_occ_d == CNT_W'(RS_SIZE));
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        if (w_alloc && w_free_idx == IDX_W'(i)) begin
          r_op[i]  <= in_op;
          r_tag[i] <= in_rob_tag;
          r_pc[i]  <= in_pc;
          r_imm[i] <= in_imm;
          r_vj[i]  <= w_in_vj;
          r_vk[i]  <= w_in_vk;
          r_qj[i]  <= w_in_qj;
          r_qk[i]  <= w_in_qk;
        end else if (r_busy[i]) begin
          if (r_qj[i] != '0 && r_qj[i] == alu_cdb_tag) begin
            r_vj[i] <= alu_cdb_val;
            r_qj[i] <= '0;
          end else if (r_qj[i] != '0 && r_qj[i] == ls_cdb_tag) begin
            r_vj[i] <= ls_cdb_val;
            r_qj[i] <= '0;
          end
          if (r_qk[i] != '0 && r_qk[i] == alu_cdb_tag) begin
            r_vk[i] <= alu_cdb_val;
            r_qk[i] <= '0;
          end else if (r_qk[i] != '0 && r_qk[i] == ls_cdb_tag) begin
            r_vk[i] <= ls_cdb_val;
            r_qk[i] <= '0;
          end
        end
      end
    end
  end

  // Data outputs hold when nothing issues; only op/tag fall back to NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_op  <= '0;
      r_out_tag <= '0;
      r_out_pc  <= '0;
      r_out_a   <= '0;
      r_out_b   <= '0;
      r_out_imm <= '0;
    end else if (!flush && w_iss_found) begin
      r_out_op  <= r_op[w_iss_idx];
      r_out_tag <= r_tag[w_iss_idx];
      r_out_pc  <= r_pc[w_iss_idx];
      r_out_a   <= r_vj[w_iss_idx];
      r_out_b   <= r_vk[w_iss_idx];
      r_out_imm <= r_imm[w_iss_idx];
    end else begin
      r_out_op  <= '0;
      r_out_tag <= '0;
    end
  end

  assign full        = r_full;
  assign occupancy   = r_occ;
  assign out_op      = r_out_op;
  assign out_rob_tag = r_out_tag;
  assign out_pc      = r_out_pc;
  assign out_a       = r_out_a;
  assign out_b       = r_out_b;
  assign out_imm     = r_out_imm;

endmodule
